// File: rtl/fill_accumulator.sv
// Operand/accumulator stage feeding an external WIDTH-bit ripple adder: holds the fill total,
// presents one increment at a time, folds the adder result back and waits for the packer when full.
module fill_accumulator #(
   parameter int               WIDTH  = 8,
   parameter logic [WIDTH-1:0] TARGET = 8'd12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             add_valid,
   input  logic [WIDTH-1:0] add_val,
   output logic             add_ready,
   input  logic [WIDTH-1:0] sum_in,
   input  logic             carry_in,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] total,
   output logic             ovf,
   output logic             box_full,
   input  logic             box_ack,
   output logic [WIDTH-1:0] box_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FULL = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] new_total;

   // A carry out means the true sum left the WIDTH-bit range, so pin the total at all-ones.
   function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] sum,
                                                 input logic             carry);
      return carry ? {WIDTH{1'b1}} : sum;
   endfunction

   assign new_total = saturate(sum_in, carry_in);

   // Ready drops combinationally on clear so a simultaneous add is refused, not half-taken.
   assign add_ready = (state == IDLE) && !clear && !rst;
   assign op_a      = total;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         total     <= '0;
         op_b      <= '0;
         ovf       <= 1'b0;
         box_full  <= 1'b0;
         box_count <= '0;
      end else if (clear) begin
         state    <= IDLE;
         total    <= '0;
         op_b     <= '0;
         ovf      <= 1'b0;
         box_full <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (add_valid) begin
                  op_b  <= add_val;
                  state <= CALC;
               end
            end
            CALC: begin
               total <= new_total;
               op_b  <= '0;
               if (carry_in) ovf <= 1'b1;
               if (new_total >= TARGET) begin
                  state    <= FULL;
                  box_full <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            FULL: begin
               if (box_ack) begin
                  total     <= '0;
                  box_count <= box_count + 1'b1;
                  box_full  <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state    <= IDLE;
               box_full <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fill_accumulator.sv
// Directed bench: three instances (TARGET 12, 255, 1) each wired to a behavioural adder.
module tb_fill_accumulator;

   logic       clk = 1'b0;
   logic       rst;
   logic       clear     [3];
   logic       add_valid [3];
   logic [7:0] add_val   [3];
   logic       box_ack   [3];
   logic       add_ready [3];
   logic [7:0] sum_in    [3];
   logic       carry_in  [3];
   logic [7:0] op_a      [3];
   logic [7:0] op_b      [3];
   logic [7:0] total     [3];
   logic       ovf       [3];
   logic       box_full  [3];
   logic [7:0] box_count [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign {carry_in[0], sum_in[0]} = {1'b0, op_a[0]} + {1'b0, op_b[0]};
   assign {carry_in[1], sum_in[1]} = {1'b0, op_a[1]} + {1'b0, op_b[1]};
   assign {carry_in[2], sum_in[2]} = {1'b0, op_a[2]} + {1'b0, op_b[2]};

   fill_accumulator #(.WIDTH(8), .TARGET(8'd12)) dut0 (
      .clk(clk), .rst(rst), .clear(clear[0]), .add_valid(add_valid[0]), .add_val(add_val[0]),
      .add_ready(add_ready[0]), .sum_in(sum_in[0]), .carry_in(carry_in[0]), .op_a(op_a[0]),
      .op_b(op_b[0]), .total(total[0]), .ovf(ovf[0]), .box_full(box_full[0]),
      .box_ack(box_ack[0]), .box_count(box_count[0]));

   fill_accumulator #(.WIDTH(8), .TARGET(8'd255)) dut1 (
      .clk(clk), .rst(rst), .clear(clear[1]), .add_valid(add_valid[1]), .add_val(add_val[1]),
      .add_ready(add_ready[1]), .sum_in(sum_in[1]), .carry_in(carry_in[1]), .op_a(op_a[1]),
      .op_b(op_b[1]), .total(total[1]), .ovf(ovf[1]), .box_full(box_full[1]),
      .box_ack(box_ack[1]), .box_count(box_count[1]));

   fill_accumulator #(.WIDTH(8), .TARGET(8'd1)) dut2 (
      .clk(clk), .rst(rst), .clear(clear[2]), .add_valid(add_valid[2]), .add_val(add_val[2]),
      .add_ready(add_ready[2]), .sum_in(sum_in[2]), .carry_in(carry_in[2]), .op_a(op_a[2]),
      .op_b(op_b[2]), .total(total[2]), .ovf(ovf[2]), .box_full(box_full[2]),
      .box_ack(box_ack[2]), .box_count(box_count[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one increment on instance k; leaves the instance in CALC with add_valid dropped.
   task automatic offer(input int k, input logic [7:0] v);
      add_valid[k] = 1'b1;
      add_val[k]   = v;
      step();
      add_valid[k] = 1'b0;
      add_val[k]   = 8'd0;
   endtask

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         clear[k] = 1'b0; add_valid[k] = 1'b0; add_val[k] = 8'd0; box_ack[k] = 1'b0;
      end
      #1;
      step();
      chk("rst_ready0", add_ready[0], 0);
      chk("rst_total0", total[0], 0);
      chk("rst_opb0", op_b[0], 0);
      chk("rst_cnt0", box_count[0], 0);
      chk("rst_ovf0", ovf[0], 0);
      chk("rst_full0", box_full[0], 0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", add_ready[0], 1);

      // add 5 then 4
      offer(0, 8'd5);
      chk("calc1_opb", op_b[0], 5);
      chk("calc1_ready", add_ready[0], 0);
      step();
      chk("total5", total[0], 5);
      chk("opb_back0", op_b[0], 0);
      chk("ready_again", add_ready[0], 1);
      offer(0, 8'd4);
      chk("calc2_opa", op_a[0], 5);
      chk("calc2_opb", op_b[0], 4);
      step();
      chk("total9", total[0], 9);
      chk("full9", box_full[0], 0);
      chk("ovf9", ovf[0], 0);

      // add 3 reaches TARGET exactly
      offer(0, 8'd3);
      step();
      chk("total12", total[0], 12);
      chk("full12", box_full[0], 1);
      chk("ready_full", add_ready[0], 0);
      box_ack[0] = 1'b1;
      step();
      box_ack[0] = 1'b0;
      chk("ack_total", total[0], 0);
      chk("ack_count", box_count[0], 1);
      chk("ack_full", box_full[0], 0);
      chk("ack_ready", add_ready[0], 1);

      // saturation on TARGET=255
      offer(1, 8'd200);
      step();
      chk("t200", total[1], 200);
      chk("t200_full", box_full[1], 0);
      offer(1, 8'd100);
      chk("sat_opa", op_a[1], 200);
      step();
      chk("sat_total", total[1], 255);
      chk("sat_ovf", ovf[1], 1);
      chk("sat_full", box_full[1], 1);
      box_ack[1] = 1'b1;
      step();
      box_ack[1] = 1'b0;
      chk("ovf_sticky", ovf[1], 1);
      chk("sat_ack_total", total[1], 0);
      clear[1] = 1'b1;
      step();
      clear[1] = 1'b0;
      chk("clr_ovf", ovf[1], 0);
      chk("clr_total", total[1], 0);
      chk("clr_keepcnt", box_count[1], 1);

      // clear together with add_valid in IDLE
      clear[0] = 1'b1; add_valid[0] = 1'b1; add_val[0] = 8'd7;
      #1;
      chk("clr_add_ready", add_ready[0], 0);
      step();
      clear[0] = 1'b0; add_valid[0] = 1'b0; add_val[0] = 8'd0;
      chk("clr_add_opb", op_b[0], 0);
      chk("clr_add_total", total[0], 0);
      #1;
      chk("clr_add_ready_next", add_ready[0], 1);

      // async reset in the middle of CALC
      offer(0, 8'd7);
      step();
      chk("t7", total[0], 7);
      offer(0, 8'd2);
      chk("pre_rst_opb", op_b[0], 2);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_total", total[0], 0);
      chk("arst_opb", op_b[0], 0);
      chk("arst_cnt", box_count[0], 0);
      chk("arst_ready", add_ready[0], 0);
      step();
      chk("arst_ready_hold", add_ready[0], 0);
      chk("arst_total_hold", total[0], 0);
      rst = 1'b0;
      #1;
      chk("arst_ready_rel", add_ready[0], 1);

      // TARGET=1: stray ack, zero increment, ack vs clear, then 256 boxes
      box_ack[2] = 1'b1;
      step();
      box_ack[2] = 1'b0;
      chk("stray_ack_cnt", box_count[2], 0);
      chk("stray_ack_ready", add_ready[2], 1);
      offer(2, 8'd0);
      step();
      chk("zero_add_total", total[2], 0);
      chk("zero_add_full", box_full[2], 0);
      offer(2, 8'd1);
      step();
      chk("t1_full", box_full[2], 1);
      box_ack[2] = 1'b1; clear[2] = 1'b1;
      step();
      box_ack[2] = 1'b0; clear[2] = 1'b0;
      chk("ackclr_cnt", box_count[2], 0);
      chk("ackclr_full", box_full[2], 0);
      chk("ackclr_total", total[2], 0);

      for (int i = 0; i < 256; i++) begin
         offer(2, 8'd1);
         step();
         chk("loop_full", box_full[2], 1);
         box_ack[2] = 1'b1;
         step();
         box_ack[2] = 1'b0;
         if (i == 254) chk("cnt255", box_count[2], 255);
      end
      chk("cnt_wrap", box_count[2], 0);
      chk("wrap_total", total[2], 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
